// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision field definitions for the float/fixed conversion chain.
package float_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

  localparam logic [FP32_EXP_W-1:0] EXP_ZERO    = '0;
  localparam logic [FP32_EXP_W-1:0] EXP_SPECIAL = '1;

endpackage

// File: rtl/iterated_float_to_fixed.sv
// Iterative fp32 -> signed WIDTH-bit integer converter, one mantissa bit per clock.
// Define ITERATED_FLOAT_TO_FIXED_ROUND_EN for round-half-away-from-zero; default truncates.
module iterated_float_to_fixed
  import float_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             start,
  output logic             ready,
  output logic             done,
  input  logic [31:0]      float,
  output logic [WIDTH-1:0] fixed,
  output logic             ovf,
  output logic             inv
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  localparam logic signed [9:0]  E_SAT   = 10'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                state;
  logic                  sign;
  logic [FP32_MAN_W-1:0] man_sr;
  logic [WIDTH-1:0]      mag;
  logic [5:0]            cnt;
  fp32_t                 op;
  logic signed [9:0]     e;
  logic [WIDTH-1:0]      sat;
  logic [WIDTH-1:0]      sum;

  assign op    = fp32_t'(float);
  assign e     = $signed({2'b00, op.exp}) - $signed(10'(FP32_BIAS));
  assign sat   = op.sign ? NEG_MIN : POS_MAX;
  assign ready = (state == IDLE);

`ifdef ITERATED_FLOAT_TO_FIXED_ROUND_EN
  logic guard;
  assign sum = mag + WIDTH'(guard);
`else
  assign sum = mag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign   <= 1'b0;
      man_sr <= '0;
      mag    <= '0;
      cnt    <= '0;
      fixed  <= '0;
      ovf    <= 1'b0;
      inv    <= 1'b0;
      done   <= 1'b0;
`ifdef ITERATED_FLOAT_TO_FIXED_ROUND_EN
      guard  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign   <= op.sign;
            man_sr <= op.man;
            mag    <= WIDTH'(1);
            cnt    <= e[5:0];
            if (op.exp == EXP_ZERO) begin
              fixed <= '0;
              ovf   <= 1'b0;
              inv   <= 1'b0;
              done  <= 1'b1;
            end else if (op.exp == EXP_SPECIAL) begin
              fixed <= (op.man != '0) ? '0 : sat;
              ovf   <= (op.man == '0);
              inv   <= (op.man != '0);
              done  <= 1'b1;
            end else if (e >= E_SAT) begin
              // -2^(WIDTH-1) is representable exactly; everything else at/above this exponent saturates
              if (op.sign && (e == E_SAT) && (op.man == '0)) begin
                fixed <= NEG_MIN;
                ovf   <= 1'b0;
              end else begin
                fixed <= sat;
                ovf   <= 1'b1;
              end
              inv  <= 1'b0;
              done <= 1'b1;
`ifdef ITERATED_FLOAT_TO_FIXED_ROUND_EN
            end else if (e == -10'sd1) begin
              mag   <= '0;
              guard <= 1'b1;
              state <= OUT;
`endif
            end else if (e < 10'sd0) begin
              fixed <= '0;
              ovf   <= 1'b0;
              inv   <= 1'b0;
              done  <= 1'b1;
            end else begin
`ifdef ITERATED_FLOAT_TO_FIXED_ROUND_EN
              guard <= op.man[FP32_MAN_W-1];
`endif
              state <= (e == 10'sd0) ? OUT : SHIFT;
            end
          end
        end

        SHIFT: begin
          mag    <= {mag[WIDTH-2:0], man_sr[FP32_MAN_W-1]};
          man_sr <= {man_sr[FP32_MAN_W-2:0], 1'b0};
          cnt    <= cnt - 6'd1;
`ifdef ITERATED_FLOAT_TO_FIXED_ROUND_EN
          guard  <= man_sr[FP32_MAN_W-2];
`endif
          if (cnt == 6'd1) state <= OUT;
        end

        OUT: begin
          // sum can only reach 2^(WIDTH-1) through rounding; that pattern is already -2^(WIDTH-1) when negated
          if (!sign && sum[WIDTH-1]) begin
            fixed <= POS_MAX;
            ovf   <= 1'b1;
          end else begin
            fixed <= sign ? -sum : sum;
            ovf   <= 1'b0;
          end
          inv   <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterated_float_to_fixed.sv
// Directed scoreboard bench for iterated_float_to_fixed at WIDTH=8 (both rounding builds).
module tb_iterated_float_to_fixed;

`ifdef ITERATED_FLOAT_TO_FIXED_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [7:0] fx;
    logic       ov;
    logic       iv;
    int         lat;
  } exp_t;

  logic        reset, clk, start, ready, done, ovf, inv;
  logic [31:0] flt;
  logic [7:0]  fixed;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_count = 0;
  int   last_acc_cyc = -1;
  int   last_done_cyc = -2;
  exp_t exp_q[$];
  int   acc_q[$];

  iterated_float_to_fixed #(.WIDTH(8)) dut (
    .reset(reset), .clk(clk), .start(start), .ready(ready), .done(done),
    .float(flt), .fixed(fixed), .ovf(ovf), .inv(inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Done monitor and acceptance tracker, sampled on the falling edge.
  always @(negedge clk) begin
    if (done) begin
      check("done_expected", 32'(exp_q.size() != 0 && acc_q.size() != 0), 32'd1);
      if (exp_q.size() != 0 && acc_q.size() != 0) begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("fixed",   32'(fixed), 32'(e.fx));
        check("ovf",     32'(ovf),   32'(e.ov));
        check("inv",     32'(inv),   32'(e.iv));
        check("latency", cyc - a,    e.lat);
        check("ready_at_done", 32'(ready), 32'd1);
      end
      last_done_cyc = cyc;
    end
    if (start && ready && !reset) begin
      acc_q.push_back(cyc);
      last_acc_cyc = cyc;
      acc_count++;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] f, input logic [7:0] fx, input logic ov,
                      input logic iv, input int lat);
    exp_t e;
    wait_ready();
    e.fx = fx; e.ov = ov; e.iv = iv; e.lat = lat;
    exp_q.push_back(e);
    flt   = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flt   = $urandom;
    if (lat > 1) check("ready_drop", 32'(ready), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    flt   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_fixed", 32'(fixed), 32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_inv",   32'(inv),   32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // normal conversions
    send(32'h40A00000, 8'h05, 1'b0, 1'b0, 4);
    send(32'hC2FE0000, 8'h81, 1'b0, 1'b0, 8);
    send(32'h42FE0000, 8'h7F, 1'b0, 1'b0, 8);
    send(32'h40200000, RND ? 8'h03 : 8'h02, 1'b0, 1'b0, 3);
    drain();

    // specials, accepted on consecutive cycles
    send(32'hC3000000, 8'h80, 1'b0, 1'b0, 1);
    send(32'h43000000, 8'h7F, 1'b1, 1'b0, 1);
    send(32'hFF800000, 8'h80, 1'b1, 1'b0, 1);
    send(32'h7F800000, 8'h7F, 1'b1, 1'b0, 1);
    send(32'h00000000, 8'h00, 1'b0, 1'b0, 1);
    send(32'h7FC00000, 8'h00, 1'b0, 1'b1, 1);
    send(32'h3E800000, 8'h00, 1'b0, 1'b0, 1);
    send(32'h00000001, 8'h00, 1'b0, 1'b0, 1);
    send(32'h43480000, 8'h7F, 1'b1, 1'b0, 1);
    send(32'hC3010000, 8'h80, 1'b1, 1'b0, 1);
    drain();

    // rounding-sensitive operands
    send(32'h3FC00000, RND ? 8'h02 : 8'h01, 1'b0, 1'b0, 2);
    send(32'hBFC00000, RND ? 8'hFE : 8'hFF, 1'b0, 1'b0, 2);
    send(32'h3F000000, RND ? 8'h01 : 8'h00, 1'b0, 1'b0, RND ? 2 : 1);
    send(32'h42FF0000, 8'h7F, RND, 1'b0, 8);
    send(32'hC2FF0000, RND ? 8'h80 : 8'h81, 1'b0, 1'b0, 8);
    drain();

    // start during SHIFT is ignored
    send(32'h42C80000, 8'h64, 1'b0, 1'b0, 8);
    @(posedge clk); #1;
    flt = 32'h40A00000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;

    // reset mid-SHIFT aborts without done
    send(32'h42C80000, 8'h64, 1'b0, 1'b0, 8);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done",  32'(done),  32'd0);
    check("abort_fixed", 32'(fixed), 32'd0);
    check("abort_ovf",   32'(ovf),   32'd0);
    repeat (12) @(posedge clk);
    #1;

    // back-to-back with start held high
    begin
      int   base, n;
      exp_t e;
      wait_ready();
      base = acc_count;
      e.fx = 8'h02; e.ov = 1'b0; e.iv = 1'b0; e.lat = 3; exp_q.push_back(e);
      e.fx = 8'h03; exp_q.push_back(e);
      flt = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      flt = 32'h40400000;
      n = 0;
      while (acc_count < base + 2 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("b2b_accepts", acc_count - base, 2);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_accept_in_done", last_acc_cyc, last_done_cyc);
      drain();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
